// File: rtl/gpr_file_pkg.sv
// Common defines for the general-purpose register file: bus widths, level
// constants and the dump engine state encoding.
package gpr_file_pkg;

    localparam int REG_W  = 32;   // register bus width
    localparam int REG_AW = 5;    // register address bus width

    localparam logic [REG_W-1:0]  ZERO_WORD = '0;
    localparam logic              WE_EN     = 1'b1;
    localparam logic              WE_DIS    = 1'b0;
    localparam logic              RE_EN     = 1'b1;
    localparam logic              RE_DIS    = 1'b0;
    localparam logic [REG_AW-1:0] NOP_ADDR  = '0;   // hardwired-zero register

    // Dump engine states
    typedef enum logic [1:0] {
        DUMP_IDLE = 2'b00,
        DUMP_RUN  = 2'b01,
        DUMP_DONE = 2'b10
    } dump_state_e;

endpackage

// File: rtl/gpr_dump_ctrl.sv
// Debug dump engine: walks every register index and streams one beat per
// index over a valid/ready handshake, then pulses done for one cycle.
// The beat is captured into a holding register so it stays stable under
// backpressure; a write landing on the capture edge is forwarded into it.
module gpr_dump_ctrl
    import gpr_file_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              dump_req,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] rd_idx,
    input  logic [DATA_W-1:0] rd_data,
    output logic              dump_busy,
    output logic              dump_valid,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    dump_state_e       r_state;
    dump_state_e       w_state_nxt;
    logic [ADDR_W-1:0] r_idx;
    logic [DATA_W-1:0] r_beat;
    logic [ADDR_W-1:0] w_idx_nxt;
    logic              w_load;
    logic [DATA_W-1:0] w_cap;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= DUMP_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next state, beat-load strobe and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_load      = 1'b0;
        dump_busy   = 1'b0;
        dump_valid  = 1'b0;
        dump_done   = 1'b0;
        case (r_state)
            DUMP_IDLE: begin
                if (dump_req) begin
                    w_state_nxt = DUMP_RUN;
                    w_idx_nxt   = '0;
                    w_load      = 1'b1;
                end
            end
            DUMP_RUN: begin
                dump_busy  = 1'b1;
                dump_valid = 1'b1;
                if (dump_ready) begin
                    if (r_idx == LAST_IDX) begin
                        w_state_nxt = DUMP_DONE;
                    end else begin
                        w_idx_nxt = r_idx + 1'b1;
                        w_load    = 1'b1;
                    end
                end
            end
            DUMP_DONE: begin
                dump_busy   = 1'b1;
                dump_done   = 1'b1;
                w_state_nxt = DUMP_IDLE;
            end
            default: w_state_nxt = DUMP_IDLE;
        endcase
    end

    // Capture sees the array as it will be after this edge's write commits
    always_comb begin
        rd_idx = w_idx_nxt;
        w_cap  = rd_data;
        if (we != WE_DIS && waddr == w_idx_nxt && w_idx_nxt != ADDR_W'(NOP_ADDR))
            w_cap = wdata;
    end

    // Index counter and beat holding register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx  <= '0;
            r_beat <= '0;
        end else if (w_load) begin
            r_idx  <= w_idx_nxt;
            r_beat <= w_cap;
        end
    end

    assign dump_addr = r_idx;
    assign dump_data = r_beat;

endmodule

// File: rtl/gpr_file.sv
// General-purpose register file: one write port from writeback, two
// combinational read ports to decode, and a debug dump engine.
// Entry 0 is hardwired to zero.
// Build option: GPR_BYPASS_EN forwards a same-cycle write to a matching
// read port; without it reads return the stored pre-edge value.
module gpr_file
    import gpr_file_pkg::*;
#(
    parameter int DATA_W   = REG_W,
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = REG_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              dump_req,
    output logic              dump_busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic              dump_done
);

    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic              w_wr_hit;
    logic [1:0]        w_re;
    logic [ADDR_W-1:0] w_raddr [2];
    logic [DATA_W-1:0] w_rdata [2];
    logic [ADDR_W-1:0] w_dump_idx;
    logic [DATA_W-1:0] w_dump_rd;

    assign w_wr_hit = (we == WE_EN) && (waddr != ADDR_W'(NOP_ADDR));

    // Register array; entry 0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
        end else if (w_wr_hit) begin
            r_regs[waddr] <= wdata;
        end
    end

    assign w_re       = {re2, re1};
    assign w_raddr[0] = raddr1;
    assign w_raddr[1] = raddr2;

    // Both read ports: disabled or r0 reads zero, otherwise stored value
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_rdata[p] = DATA_W'(ZERO_WORD);
            if (w_re[p] == RE_EN && w_raddr[p] != ADDR_W'(NOP_ADDR)) begin
                w_rdata[p] = r_regs[w_raddr[p]];
`ifdef GPR_BYPASS_EN
                if (w_wr_hit && waddr == w_raddr[p]) w_rdata[p] = wdata;
`endif
            end
        end
    end

    assign rdata1 = w_rdata[0];
    assign rdata2 = w_rdata[1];

    assign w_dump_rd = r_regs[w_dump_idx];

    gpr_dump_ctrl #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (ADDR_W)
    ) u_dump (
        .clk        (clk),
        .rst        (rst),
        .we         (we),
        .waddr      (waddr),
        .wdata      (wdata),
        .dump_req   (dump_req),
        .dump_ready (dump_ready),
        .rd_idx     (w_dump_idx),
        .rd_data    (w_dump_rd),
        .dump_busy  (dump_busy),
        .dump_valid (dump_valid),
        .dump_addr  (dump_addr),
        .dump_data  (dump_data),
        .dump_done  (dump_done)
    );

endmodule

// File: tb/tb_gpr_file.sv
// Self-checking bench for gpr_file: register array model plus per-beat
// dump expectations taken from the model at each capture edge.
module tb_gpr_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1, re2;
    logic [4:0]  raddr1, raddr2;
    logic [31:0] rdata1, rdata2;
    logic        dump_req, dump_ready;
    logic        dump_busy, dump_valid, dump_done;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;

    int          vecs = 0;
    int          errs = 0;
    logic [31:0] model [32];

    always #5 clk = ~clk;

    gpr_file dut (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .re1(re1), .raddr1(raddr1), .rdata1(rdata1),
        .re2(re2), .raddr2(raddr2), .rdata2(rdata2),
        .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
        .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_done(dump_done)
    );

    // One rising edge; the model commits the write the DUT sees on it
    task automatic tick();
        logic        w;
        logic [4:0]  a;
        logic [31:0] d;
        w = we; a = waddr; d = wdata;
        @(posedge clk);
        if (rst && w && a != 5'd0) model[a] = d;
        #1;
    endtask

    function automatic logic [31:0] exp_rd(input logic re, input logic [4:0] a);
        if (!re || a == 5'd0) return 32'd0;
`ifdef GPR_BYPASS_EN
        if (we && waddr == a) return wdata;
`endif
        return model[a];
    endfunction

    task automatic test_reset();
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        repeat (3) tick();
        re1 = 1'b1; raddr1 = 5'd9; #1;
        vecs++;
        if (rdata1 !== 32'd0) begin errs++; $display("FAIL reset_rdata1 got %h exp 0", rdata1); end
        vecs++;
        if ({dump_busy, dump_valid, dump_done} !== 3'b000 || dump_addr !== 5'd0 || dump_data !== 32'd0) begin
            errs++; $display("FAIL reset_dump got b%b v%b d%b a%0d data %h exp all 0",
                             dump_busy, dump_valid, dump_done, dump_addr, dump_data);
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        logic [31:0] e;
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF; re1 = 1'b1; raddr1 = 5'd5; #1;
`ifdef GPR_BYPASS_EN
        e = 32'hDEADBEEF;
`else
        e = 32'd0;
`endif
        vecs++;
        if (rdata1 !== e) begin errs++; $display("FAIL wr_before_edge got %h exp %h", rdata1, e); end
        tick();
        we = 1'b0; #1;
        vecs++;
        if (rdata1 !== 32'hDEADBEEF) begin errs++; $display("FAIL wr_after_edge got %h exp deadbeef", rdata1); end
    endtask

    task automatic test_r0();
        we = 1'b1; waddr = 5'd0; wdata = 32'h12345678;
        re1 = 1'b1; raddr1 = 5'd0; re2 = 1'b0; raddr2 = 5'd5; #1;
        vecs++;
        if (rdata1 !== 32'd0) begin errs++; $display("FAIL r0_bypass got %h exp 0", rdata1); end
        vecs++;
        if (rdata2 !== 32'd0) begin errs++; $display("FAIL re2_off got %h exp 0", rdata2); end
        tick();
        we = 1'b0; #1;
        vecs++;
        if (rdata1 !== 32'd0) begin errs++; $display("FAIL r0_after got %h exp 0", rdata1); end
    endtask

    task automatic test_same_cycle();
        logic [31:0] e;
        we = 1'b1; waddr = 5'd7; wdata = 32'h0BADF00D; tick();
        wdata = 32'hA5A5A5A5; re2 = 1'b1; raddr2 = 5'd7; re1 = 1'b1; raddr1 = 5'd7; #1;
`ifdef GPR_BYPASS_EN
        e = 32'hA5A5A5A5;
`else
        e = 32'h0BADF00D;
`endif
        vecs++;
        if (rdata2 !== e) begin errs++; $display("FAIL same_cycle_p2 got %h exp %h", rdata2, e); end
        vecs++;
        if (rdata1 !== e) begin errs++; $display("FAIL same_cycle_p1 got %h exp %h", rdata1, e); end
        tick();
        we = 1'b0; #1;
        vecs++;
        if (rdata2 !== 32'hA5A5A5A5) begin errs++; $display("FAIL same_cycle_after got %h exp a5a5a5a5", rdata2); end
    endtask

    task automatic test_random_rw();
        logic [31:0] e1, e2;
        for (int n = 0; n < 300; n++) begin
            we = 1'($urandom); waddr = 5'($urandom); wdata = $urandom;
            re1 = ($urandom_range(0, 7) != 0); re2 = ($urandom_range(0, 7) != 0);
            raddr1 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            raddr2 = ($urandom_range(0, 2) == 0) ? waddr : 5'($urandom);
            #1;
            e1 = exp_rd(re1, raddr1);
            e2 = exp_rd(re2, raddr2);
            vecs++;
            if (rdata1 !== e1) begin errs++; $display("FAIL rand_p1 a%0d got %h exp %h", raddr1, rdata1, e1); end
            vecs++;
            if (rdata2 !== e2) begin errs++; $display("FAIL rand_p2 a%0d got %h exp %h", raddr2, rdata2, e2); end
            tick();
        end
        we = 1'b0;
    endtask

    // Starts a dump from IDLE and drains it; beat k expected as given
    task automatic run_dump_check(input string tag, input logic [31:0] exp_beats [32]);
        dump_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
        for (int k = 0; k < 32; k++) begin
            #1;
            vecs++;
            if (dump_valid !== 1'b1 || dump_addr !== 5'(k) || dump_data !== exp_beats[k]) begin
                errs++; $display("FAIL %s beat%0d got v%b a%0d %h exp v1 a%0d %h",
                                 tag, k, dump_valid, dump_addr, dump_data, k, exp_beats[k]);
            end
            tick();
        end
        vecs++;
        if (dump_done !== 1'b1 || dump_busy !== 1'b1 || dump_valid !== 1'b0) begin
            errs++; $display("FAIL %s done_cycle got d%b b%b v%b exp d1 b1 v0", tag, dump_done, dump_busy, dump_valid);
        end
        tick();
        vecs++;
        if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
            errs++; $display("FAIL %s after_done got d%b b%b exp d0 b0", tag, dump_done, dump_busy);
        end
    endtask

    task automatic test_full_dump();
        logic [31:0] eb [32];
        we = 1'b1;
        for (int i = 1; i < 32; i++) begin waddr = 5'(i); wdata = i * 32'h11; tick(); end
        we = 1'b0;
        for (int k = 0; k < 32; k++) eb[k] = k * 32'h11;
        run_dump_check("full_dump", eb);
    endtask

    task automatic test_backpressure();
        logic [31:0] eb [32];
        dump_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
        repeat (3) tick();
        dump_ready = 1'b0; we = 1'b1; waddr = 5'd3; wdata = 32'hFFFF0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            vecs++;
            if (dump_valid !== 1'b1 || dump_addr !== 5'd3 || dump_data !== 32'h33) begin
                errs++; $display("FAIL bp_hold c%0d got v%b a%0d %h exp v1 a3 00000033", c, dump_valid, dump_addr, dump_data);
            end
            tick();
            we = 1'b0;
        end
        dump_ready = 1'b1;
        for (int k = 3; k < 32; k++) tick();
        #1;
        vecs++;
        if (dump_done !== 1'b1) begin errs++; $display("FAIL bp_done got %b exp 1", dump_done); end
        tick();
        for (int k = 0; k < 32; k++) eb[k] = k * 32'h11;
        eb[3] = 32'hFFFF0000;
        run_dump_check("bp_second", eb);
    endtask

    // Random ready, random writes and stray dump_req pulses during a dump
    task automatic test_random_dump();
        logic [31:0] exp_beat;
        int          k;
        int          cyc;
        logic        xfer;
        k = 0; cyc = 0;
        dump_ready = 1'b0; dump_req = 1'b1; tick();
        exp_beat = model[0];
        while (k < 32 && cyc < 2000) begin
            dump_req = ($urandom_range(0, 9) == 0);
            dump_ready = 1'($urandom);
            we = 1'($urandom); wdata = $urandom;
            waddr = ($urandom_range(0, 1) == 0) ? 5'(k) : 5'($urandom);
            if (k < 31 && $urandom_range(0, 2) == 0) waddr = 5'(k + 1);
            #1;
            vecs++;
            if (dump_valid !== 1'b1 || dump_addr !== 5'(k) || dump_data !== exp_beat) begin
                errs++; $display("FAIL rdump beat%0d got v%b a%0d %h exp v1 a%0d %h",
                                 k, dump_valid, dump_addr, dump_data, k, exp_beat);
            end
            xfer = dump_ready;
            tick();
            cyc++;
            if (xfer) begin
                k++;
                if (k < 32) exp_beat = model[k];
            end
        end
        we = 1'b0; dump_req = 1'b0; #1;
        vecs++;
        if (k != 32) begin errs++; $display("FAIL rdump_timeout beats %0d exp 32", k); end
        vecs++;
        if (dump_done !== 1'b1) begin errs++; $display("FAIL rdump_done got %b exp 1", dump_done); end
        tick();
        vecs++;
        if (dump_busy !== 1'b0) begin errs++; $display("FAIL rdump_idle got %b exp 0", dump_busy); end
    endtask

    task automatic test_reset_mid_dump();
        dump_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
        repeat (10) tick();
        #1;
        vecs++;
        if (dump_addr !== 5'd10 || dump_valid !== 1'b1) begin
            errs++; $display("FAIL mid_pre got a%0d v%b exp a10 v1", dump_addr, dump_valid);
        end
        rst = 1'b0;
        for (int i = 0; i < 32; i++) model[i] = 32'd0;
        #1;
        vecs++;
        if (dump_valid !== 1'b0 || dump_busy !== 1'b0 || dump_done !== 1'b0) begin
            errs++; $display("FAIL mid_abort got v%b b%b d%b exp 0 0 0", dump_valid, dump_busy, dump_done);
        end
        tick();
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            vecs++;
            if (dump_done !== 1'b0 || dump_busy !== 1'b0) begin
                errs++; $display("FAIL mid_no_done c%0d got d%b b%b exp 0 0", c, dump_done, dump_busy);
            end
            tick();
        end
        re1 = 1'b1; re2 = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr1 = 5'(a); raddr2 = 5'(31 - a); #1;
            vecs++;
            if (rdata1 !== 32'd0 || rdata2 !== 32'd0) begin
                errs++; $display("FAIL mid_clear a%0d got %h %h exp 0", a, rdata1, rdata2);
            end
        end
    endtask

    initial begin
        rst = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b0; re2 = 1'b0; raddr1 = '0; raddr2 = '0;
        dump_req = 1'b0; dump_ready = 1'b0;
        test_reset();
        test_write_read();
        test_r0();
        test_same_cycle();
        test_random_rw();
        test_full_dump();
        test_backpressure();
        test_random_dump();
        test_reset_mid_dump();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
